instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
Program sequencer directly upstream of the cpu core. It owns the program counter and reads 16-bit instruction words from a synchronous instruction memory. It presents each word on the core's instruction input with the one-cycle load and start strobes, then waits for the core's w (waiting) flag before fetching the next word. It also applies taken-branch redirects, detects a HALT word, and counts retired instructions.

Parameters:
PC_W, 8, program counter and memory address width
DATA_W, 16, instruction word width
HALT_WORD, 16'hE000, fetched word that stops sequencing; it is never issued to the core

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
run  input  1  level; leaves IDLE when 1
mem_addr  output  PC_W  instruction memory address (equals pc)
mem_rd  output  1  memory read strobe; rdata is valid the next cycle
mem_rdata  input  DATA_W  memory read data
cpu_in  output  DATA_W  instruction word to core
cpu_load  output  1  one-cycle instruction-register load strobe to core
cpu_s  output  1  one-cycle start strobe to core
cpu_w  input  1  core waiting flag; 1 means the core is idle
br_valid  input  1  taken-branch pulse, honoured only in EXEC
br_target  input  PC_W  branch destination
pc  output  PC_W  current program counter
halted  output  1  sticky; HALT_WORD was fetched
retired  output  16  count of instructions issued

Behaviour:
- Reset (asynchronous, any state, including mid-instruction):
  - state=IDLE; pc=0, cpu_in=0, retired=0, halted=0.
  - cpu_load, cpu_s, mem_rd are 0.
  - br_pend is cleared.
- States and transitions (one transition per clk):
  - IDLE: if run=1, go to WAIT.
  - WAIT: if cpu_w=1, go to FETCH.
  - FETCH: mem_rd=1, mem_addr=pc; go to CAPT.
  - CAPT: if mem_rdata==HALT_WORD, set halted=1 and go to HALTED. Otherwise cpu_in<=mem_rdata and go to LOAD.
  - LOAD: cpu_load=1; go to START.
  - START: cpu_s=1; retired<=retired+1, wrapping at 16'hFFFF to 0; go to EXEC.
  - EXEC: stays at least 1 cycle, so the core has time to drop w.
    - On any cycle after the first with cpu_w=1: pc<=br_pend ? br_tgt : pc+1 (modulo 2^PC_W, so 255 wraps to 0); clear br_pend; go to FETCH.
  - HALTED: terminal until reset. run, br_valid and cpu_w are ignored; pc holds the HALT address.
- Output timing:
  - cpu_load, cpu_s and mem_rd are Moore outputs decoded from the state register.
  - Each is high for exactly one cycle per instruction.
  - cpu_in is stable from LOAD until the next CAPT.
- Branch handling:
  - br_valid is sampled only in EXEC. It sets br_pend=1 and br_tgt<=br_target.
  - If several pulses arrive, the last one wins.
  - A br_valid in the same cycle that EXEC exits is applied immediately: pc<=br_target.
  - br_valid in any other state is ignored.
- Latency: 4 cycles from FETCH to cpu_s (FETCH, CAPT, LOAD, START), plus the core's execute time.
- run dropping to 0 after IDLE has no effect; sequencing continues until HALT or reset.

Decomposition:
- Shared package contents:
  - fetch_state_t enum: IDLE, WAIT, FETCH, CAPT, LOAD, START, EXEC, HALTED.
  - HALT_WORD default.
  - Shared width constant for the instruction word (16).
- One sub-module is natural: pc_unit. It holds the pc register, the br_pend/br_tgt capture, and the increment/redirect mux, enabled by an advance strobe from the FSM.
- Reuse the existing enable-flop for cpu_in.

Test Plan:
- Reset mid-EXEC with pc=5 and retired=3 -> all outputs read 0 on the same edge; state returns to IDLE.
- Memory holds words A,B,HALT at 0..2; run=1; cpu model raises w 3 cycles after each cpu_s -> cpu_s pulses twice; cpu_in equals A then B; retired=2; halted=1; pc=2; no cpu_load for HALT.
- cpu_w=1 in IDLE with run=1 -> cpu_load asserts exactly 3 cycles after WAIT is entered, and cpu_s on the following cycle.
- br_valid=1 with br_target=8'h40 during EXEC of the instruction at pc=3 -> next mem_addr=8'h40, not 4; a br_valid during LOAD is ignored.
- pc=8'hFF with a non-branching instruction -> next fetch at mem_addr=0.
- Two br_valid pulses in EXEC (targets 10, then 20) -> next fetch at 20; in HALTED, br_valid and run toggling leave pc and halted unchanged.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction sequencer that feeds the cpu core.
package instr_fetch_pkg;

    localparam int                DEF_PC_W      = 8;
    localparam int                INSTR_W       = 16;
    localparam int                RET_W         = 16;
    localparam logic [INSTR_W-1:0] DEF_HALT_WORD = 16'hE000;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        FETCH,
        CAPT,
        LOAD,
        START,
        EXEC,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Memory-read and core-issue signals between the sequencer (master) and memory/core (slave).
interface instr_fetch_if #(
    parameter int PC_W   = instr_fetch_pkg::DEF_PC_W,
    parameter int DATA_W = instr_fetch_pkg::INSTR_W
);

    logic [PC_W-1:0]   mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] cpu_in;
    logic              cpu_load;
    logic              cpu_s;
    logic              cpu_w;

    // mem_rd is a one-cycle request; mem_rdata is valid the following cycle.
    // cpu_load then cpu_s are one-cycle valids for cpu_in; cpu_w=1 acts as
    // the core's ready, and no new word is issued until it returns high.
    modport master (
        output mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
        input  mem_rdata, cpu_w
    );

    modport slave (
        input  mem_addr, mem_rd, cpu_in, cpu_load, cpu_s,
        output mem_rdata, cpu_w
    );

endinterface

// File: rtl/instr_fetch_pc_unit.sv
// Program counter with deferred branch capture; moves only on the advance strobe.
module instr_fetch_pc_unit #(
    parameter int PC_W = instr_fetch_pkg::DEF_PC_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance_i,
    input  logic            br_cap_i,
    input  logic [PC_W-1:0] br_target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] br_tgt_q, br_tgt_d;
    logic            br_pend_q, br_pend_d;

    // A branch seen on the advancing cycle overrides any earlier pending one.
    always_comb begin
        pc_d      = pc_q;
        br_tgt_d  = br_tgt_q;
        br_pend_d = br_pend_q;
        if (advance_i) begin
            if (br_cap_i) begin
                pc_d = br_target_i;
            end else if (br_pend_q) begin
                pc_d = br_tgt_q;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
            br_pend_d = 1'b0;
        end else if (br_cap_i) begin
            br_pend_d = 1'b1;
            br_tgt_d  = br_target_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q      <= '0;
            br_tgt_q  <= '0;
            br_pend_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            br_tgt_q  <= br_tgt_d;
            br_pend_q <= br_pend_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer: fetches a word, issues it to the core with load/start
// strobes, waits for the core to finish, then advances or redirects the pc.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                PC_W      = DEF_PC_W,
    parameter int                DATA_W    = INSTR_W,
    parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    instr_fetch_if.master     bus,
    input  logic              br_valid,
    input  logic [PC_W-1:0]   br_target,
    output logic [PC_W-1:0]   pc,
    output logic              halted,
    output logic [RET_W-1:0]  retired,
    output fetch_state_t      dbg_state
);

    fetch_state_t      state_q;
    logic              exec_first_q;
    logic [DATA_W-1:0] cpu_in_q;
    logic              halted_q;
    logic [RET_W-1:0]  retired_q;
    logic              in_exec;
    logic              advance;
    logic              br_cap;

    // The first EXEC cycle ignores cpu_w so the core has time to drop it.
    assign in_exec = (state_q == EXEC);
    assign advance = in_exec && !exec_first_q && bus.cpu_w;
    assign br_cap  = in_exec && br_valid;

    instr_fetch_pc_unit #(.PC_W(PC_W)) u_pc (
        .clk         (clk),
        .reset       (reset),
        .advance_i   (advance),
        .br_cap_i    (br_cap),
        .br_target_i (br_target),
        .pc_o        (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            exec_first_q <= 1'b0;
            cpu_in_q     <= '0;
            halted_q     <= 1'b0;
            retired_q    <= '0;
        end else begin
            case (state_q)
                IDLE:   if (run) state_q <= WAIT;
                WAIT:   if (bus.cpu_w) state_q <= FETCH;
                FETCH:  state_q <= CAPT;
                CAPT: begin
                    if (bus.mem_rdata == HALT_WORD) begin
                        halted_q <= 1'b1;
                        state_q  <= HALTED;
                    end else begin
                        cpu_in_q <= bus.mem_rdata;
                        state_q  <= LOAD;
                    end
                end
                LOAD:   state_q <= START;
                START: begin
                    retired_q    <= retired_q + RET_W'(1);
                    exec_first_q <= 1'b1;
                    state_q      <= EXEC;
                end
                EXEC: begin
                    exec_first_q <= 1'b0;
                    if (advance) state_q <= FETCH;
                end
                HALTED: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr = pc;
    assign bus.mem_rd   = (state_q == FETCH);
    assign bus.cpu_load = (state_q == LOAD);
    assign bus.cpu_s    = (state_q == START);
    assign bus.cpu_in   = cpu_in_q;
    assign halted       = halted_q;
    assign retired      = retired_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: synchronous memory, a responsive core model and a
// program-level reference model that predicts fetch addresses and issued words.
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    localparam logic [15:0] HALT = 16'hE000;

    // clock / reset
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         run = 1'b0;
    logic         br_valid = 1'b0;
    logic [7:0]   br_target = 8'h00;
    logic [7:0]   pc;
    logic         halted;
    logic [15:0]  retired;
    fetch_state_t dbg_state;

    instr_fetch_if bus ();

    instr_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .bus       (bus),
        .br_valid  (br_valid),
        .br_target (br_target),
        .pc        (pc),
        .halted    (halted),
        .retired   (retired),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // reference model state and scoreboard
    logic [15:0] exp_q[$];
    logic [7:0]  model_pc;
    int          n_issued;
    int          plan_n [256];
    logic [7:0]  plan_t0 [256];
    logic [7:0]  plan_t1 [256];
    int          lat_min, lat_max, br_pct;
    bit          junk_br;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; br_valid = 1'b0; br_target = 8'h00; bus.cpu_w = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_pc = 8'h00; n_issued = 0; exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            plan_n[i] = 0; plan_t0[i] = 8'h00; plan_t1[i] = 8'h00;
        end
    endtask

    task automatic fill_linear();
        for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    endtask

    // Runs the program from IDLE; returns at HALT, or one EXEC cycle after
    // the stop_issues-th cpu_s when stop_issues is non-zero.
    task automatic run_prog(input int stop_issues, input int budget);
        int cyc, f_cyc, next_rd, exec_left, w_cnt, lat, nb;
        bit is_halt, br_taken, done, stop_pending;
        logic [7:0]  br_t;
        logic [15:0] cur_word, exp_w;
        cyc = 0; f_cyc = -10; next_rd = 2; exec_left = 0; w_cnt = 0; nb = 0;
        is_halt = 1'b0; br_taken = 1'b0; done = 1'b0; stop_pending = 1'b0;
        br_t = 8'h00; cur_word = 16'h0000;
        run = 1'b1; bus.cpu_w = 1'b1; br_valid = 1'b0;
        while (!done) begin
            @(negedge clk);
            cyc++;
            br_valid = 1'b0;
            chk("mem_rd", bus.mem_rd, cyc == next_rd);
            if (cyc == next_rd) begin
                chk("mem_addr", bus.mem_addr, model_pc);
                f_cyc = cyc;
                cur_word = mem[model_pc];
                is_halt = (cur_word == HALT);
                if (!is_halt) exp_q.push_back(cur_word);
            end
            chk("cpu_load", bus.cpu_load, !is_halt && cyc == f_cyc + 2);
            chk("cpu_s", bus.cpu_s, !is_halt && cyc == f_cyc + 3);
            chk("halted", halted, is_halt && cyc >= f_cyc + 2);
            if (!is_halt && cyc == f_cyc + 2) begin
                chk("exp_q_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    exp_w = exp_q.pop_front();
                    chk("cpu_in_load", bus.cpu_in, exp_w);
                end
                if (junk_br) begin
                    br_valid = 1'b1; br_target = 8'($urandom_range(0, 255));
                end
            end
            if (!is_halt && cyc == f_cyc + 3) begin
                chk("cpu_in_start", bus.cpu_in, cur_word);
                chk("retired_start", retired, n_issued);
                n_issued++;
                bus.cpu_w = 1'b0;
                lat = int'($urandom_range(lat_min, lat_max));
                w_cnt = lat;
                exec_left = (lat < 2) ? 2 : lat;
                br_taken = 1'b0; nb = 0;
                if (stop_issues != 0 && n_issued == stop_issues) stop_pending = 1'b1;
            end else if (exec_left > 0) begin
                chk("cpu_in_exec", bus.cpu_in, cur_word);
                if (nb < plan_n[model_pc]) begin
                    br_valid = 1'b1;
                    br_target = (nb == 0) ? plan_t0[model_pc] : plan_t1[model_pc];
                    nb++;
                end else if (n_issued < 30 && int'($urandom_range(0, 99)) < br_pct) begin
                    br_valid = 1'b1; br_target = 8'($urandom_range(0, 255));
                end
                if (br_valid) begin
                    br_taken = 1'b1; br_t = br_target;
                end
                w_cnt--;
                if (w_cnt == 0) bus.cpu_w = 1'b1;
                exec_left--;
                if (exec_left == 0) begin
                    plan_n[model_pc] = 0;
                    model_pc = br_taken ? br_t : 8'(model_pc + 8'd1);
                    next_rd = cyc + 1;
                end
                if (stop_pending) done = 1'b1;
            end
            if (is_halt && cyc == f_cyc + 2) done = 1'b1;
            chk("cycle_budget", cyc < budget, 1);
            if (cyc >= budget) done = 1'b1;
        end
        br_valid = 1'b0;
    endtask

    // In HALTED every input is noise; nothing may move.
    task automatic post_halt(input int n);
        logic [7:0] hpc;
        hpc = model_pc;
        for (int i = 0; i < n; i++) begin
            run = 1'($urandom_range(0, 1));
            br_valid = 1'($urandom_range(0, 1));
            br_target = 8'($urandom_range(0, 255));
            bus.cpu_w = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("halt_pc", pc, hpc);
            chk("halt_flag", halted, 1);
            chk("halt_rd", bus.mem_rd, 0);
            chk("halt_load", bus.cpu_load, 0);
            chk("halt_s", bus.cpu_s, 0);
            chk("halt_retired", retired, n_issued);
        end
        br_valid = 1'b0;
        chk("halt_exp_q_empty", exp_q.size(), 0);
    endtask

    initial begin
        bus.cpu_w = 1'b1;
        lat_min = 3; lat_max = 3; br_pct = 0; junk_br = 1'b0;
        fill_linear();
        @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_halted", halted, 0);
        chk("rst_cpu_in", bus.cpu_in, 0);
        chk("rst_load", bus.cpu_load, 0);
        chk("rst_s", bus.cpu_s, 0);
        chk("rst_rd", bus.mem_rd, 0);
        chk("rst_state", dbg_state, IDLE);

        // A, B, HALT with a fixed 3-cycle core
        do_reset();
        mem[0] = 16'hA0A1; mem[1] = 16'hB0B1; mem[2] = HALT;
        run_prog(0, 500);
        chk("ab_pc", pc, 8'h02);
        chk("ab_retired", retired, 16'd2);
        chk("ab_halted", halted, 1);
        post_halt(6);

        // taken branch at pc=3 to 0x40, with ignored pulses during LOAD
        do_reset();
        fill_linear();
        mem[8'h41] = HALT;
        plan_n[3] = 1; plan_t0[3] = 8'h40;
        lat_min = 1; lat_max = 4; junk_br = 1'b1;
        run_prog(0, 500);
        chk("br_pc", pc, 8'h41);
        chk("br_retired", retired, 16'd5);

        // pc wraps from 0xFF to 0x00
        do_reset();
        fill_linear();
        mem[1] = HALT;
        plan_n[0] = 1; plan_t0[0] = 8'hFF;
        junk_br = 1'b0;
        run_prog(0, 500);
        chk("wrap_pc", pc, 8'h01);
        chk("wrap_retired", retired, 16'd3);

        // two pulses in one EXEC: the later target wins
        do_reset();
        fill_linear();
        mem[20] = HALT;
        plan_n[0] = 2; plan_t0[0] = 8'd10; plan_t1[0] = 8'd20;
        lat_min = 2; lat_max = 4;
        run_prog(0, 500);
        chk("two_br_pc", pc, 8'd20);
        chk("two_br_retired", retired, 16'd1);
        post_halt(12);

        // asynchronous reset in EXEC with pc=5, retired=3
        do_reset();
        fill_linear();
        plan_n[0] = 1; plan_t0[0] = 8'h04;
        lat_min = 3; lat_max = 3;
        run_prog(3, 500);
        chk("pre_rst_pc", pc, 8'h05);
        chk("pre_rst_retired", retired, 16'd3);
        chk("pre_rst_state", dbg_state, EXEC);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_retired", retired, 0);
        chk("arst_cpu_in", bus.cpu_in, 0);
        chk("arst_halted", halted, 0);
        chk("arst_load", bus.cpu_load, 0);
        chk("arst_s", bus.cpu_s, 0);
        chk("arst_rd", bus.mem_rd, 0);
        chk("arst_state", dbg_state, IDLE);

        // random programs, random core latency and random branches
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                mem[i] = 16'($urandom);
                if (mem[i] == HALT) mem[i] = mem[i] ^ 16'h0001;
            end
            mem[8'($urandom_range(0, 255))] = HALT;
            mem[8'($urandom_range(0, 255))] = HALT;
            lat_min = 1; lat_max = 5; br_pct = 25; junk_br = 1'b1;
            run_prog(0, 8000);
            chk("rnd_retired", retired, n_issued);
            chk("rnd_pc", pc, model_pc);
            post_halt(4);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
